// File: rtl/oob_host_ctrl.sv
// oob_host_ctrl: host-side SATA OOB initiator, COMRESET through link up
module oob_host_ctrl #(
    parameter int DATA_BYTE_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES   = 1000,
    parameter int NOCOMWAKE_CYCLES = 38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gtx_ready,
    input  logic        oob_start,
    input  logic        rxcominitdet_in,
    input  logic        rxcomwakedet_in,
    input  logic        rxelecidle_in,
    input  logic [31:0] rxdata_in,
    input  logic [3:0]  rxcharisk_in,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle,
    output logic [31:0] txdata_out,
    output logic [3:0]  txcharisk_out,
    output logic        link_up,
    output logic        oob_busy,
    output logic        oob_silence,
    output logic        oob_error
);
    localparam logic [31:0] D102  = 32'h4A4A4A4A;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int QW = $clog2(NOCOMWAKE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_COMRESET, S_WAIT_COMINIT, S_COMWAKE, S_WAIT_COMWAKE,
        S_WAIT_NOCOMWAKE, S_SEND_D102, S_SEND_ALIGN, S_READY, S_ERROR
    } state_t;

    if (DATA_BYTE_WIDTH != 4) begin : g_width_check
        $error("oob_host_ctrl supports only DATA_BYTE_WIDTH == 4");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          cominit_q, comwake_q, elecidle_q;
    logic [31:0]   rxdata_q;
    logic [3:0]    rxcharisk_q;
    logic          txcominit_q, txcominit_d, txcomwake_q, txcomwake_d;
    logic          txelecidle_q, txelecidle_d, link_up_q, link_up_d;
    logic          silence_q, silence_d, error_q, error_d;
    logic [31:0]   txdata_q, txdata_d;
    logic [3:0]    txcharisk_q, txcharisk_d;
    logic          rst_c, aligndet, syncdet, timeout, timed;

    assign rst_c    = rst | ~gtx_ready;
    assign aligndet = (rxdata_q == ALIGN) && (rxcharisk_q == 4'h1);
    assign syncdet  = (rxdata_q == SYNC) && (rxcharisk_q == 4'h1);
    assign timeout  = timer_q == TW'(TIMEOUT_CYCLES - 1);
    assign timed    = state_q inside {S_WAIT_COMINIT, S_WAIT_COMWAKE, S_SEND_D102, S_SEND_ALIGN};

    // Next state and next registered outputs; detects are checked before timeouts so they win a tie
    always_comb begin
        state_d      = state_q;
        quiet_d      = quiet_q;
        txcominit_d  = 1'b0;
        txcomwake_d  = 1'b0;
        silence_d    = 1'b0;
        error_d      = 1'b0;
        txelecidle_d = txelecidle_q;
        txdata_d     = txdata_q;
        txcharisk_d  = txcharisk_q;
        case (state_q)
            S_IDLE: if (oob_start) begin
                state_d     = S_COMRESET;
                txcominit_d = 1'b1;
            end
            S_COMRESET: state_d = S_WAIT_COMINIT;
            S_WAIT_COMINIT: if (cominit_q) begin
                state_d     = S_COMWAKE;
                txcomwake_d = 1'b1;
            end else if (timeout) begin
                state_d   = S_IDLE;
                silence_d = 1'b1;
            end
            S_COMWAKE: state_d = S_WAIT_COMWAKE;
            S_WAIT_COMWAKE: state_d = comwake_q ? S_WAIT_NOCOMWAKE : timeout ? S_ERROR : S_WAIT_COMWAKE;
            S_WAIT_NOCOMWAKE: if (comwake_q) begin
                quiet_d = '0;
            end else if (quiet_q == QW'(NOCOMWAKE_CYCLES - 1)) begin
                state_d      = S_SEND_D102;
                txelecidle_d = 1'b0;
                txdata_d     = D102;
                txcharisk_d  = 4'h0;
            end else begin
                quiet_d = quiet_q + 1'b1;
            end
            S_SEND_D102: if (aligndet) begin
                state_d     = S_SEND_ALIGN;
                txdata_d    = ALIGN;
                txcharisk_d = 4'h1;
            end else if (timeout) begin
                state_d = S_ERROR;
            end
            S_SEND_ALIGN: if (syncdet) begin
                state_d     = S_READY;
                txdata_d    = SYNC;
                txcharisk_d = 4'h1;
            end else if (timeout) begin
                state_d = S_ERROR;
            end
            S_READY: state_d = elecidle_q ? S_ERROR : S_READY;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERROR) begin
            error_d      = 1'b1;
            txelecidle_d = 1'b1;
            txdata_d     = '0;
            txcharisk_d  = '0;
        end
        if (state_q != S_WAIT_NOCOMWAKE) quiet_d = '0;
        link_up_d = state_d == S_READY;
        timer_d   = (state_d != state_q || !timed) ? '0 : timer_q + 1'b1;
    end

    // Register rx inputs, state, timers and all outputs; reset or a not-ready transceiver forces idle
    always_ff @(posedge clk) begin
        if (rst_c) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            quiet_q      <= '0;
            cominit_q    <= 1'b0;
            comwake_q    <= 1'b0;
            elecidle_q   <= 1'b0;
            rxdata_q     <= '0;
            rxcharisk_q  <= '0;
            txcominit_q  <= 1'b0;
            txcomwake_q  <= 1'b0;
            txelecidle_q <= 1'b1;
            txdata_q     <= '0;
            txcharisk_q  <= '0;
            link_up_q    <= 1'b0;
            silence_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            quiet_q      <= quiet_d;
            cominit_q    <= rxcominitdet_in;
            comwake_q    <= rxcomwakedet_in;
            elecidle_q   <= rxelecidle_in;
            rxdata_q     <= rxdata_in;
            rxcharisk_q  <= rxcharisk_in;
            txcominit_q  <= txcominit_d;
            txcomwake_q  <= txcomwake_d;
            txelecidle_q <= txelecidle_d;
            txdata_q     <= txdata_d;
            txcharisk_q  <= txcharisk_d;
            link_up_q    <= link_up_d;
            silence_q    <= silence_d;
            error_q      <= error_d;
        end
    end

    assign txcominit     = txcominit_q;
    assign txcomwake     = txcomwake_q;
    assign txelecidle    = txelecidle_q;
    assign txdata_out    = txdata_q;
    assign txcharisk_out = txcharisk_q;
    assign link_up       = link_up_q;
    assign oob_silence   = silence_q;
    assign oob_error     = error_q;
    assign oob_busy      = (state_q != S_IDLE) && (state_q != S_READY);
endmodule

// File: tb/tb_oob_host_ctrl.sv
// tb_oob_host_ctrl: directed vectors and timed sequences for the OOB host controller
module tb_oob_host_ctrl;
    localparam logic [31:0] D102  = 32'h4A4A4A4A;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst = 1'b1, gtx_ready = 1'b1, oob_start = 1'b0;
    logic        rxcominitdet_in = 1'b0, rxcomwakedet_in = 1'b0, rxelecidle_in = 1'b0;
    logic [31:0] rxdata_in = '0;
    logic [3:0]  rxcharisk_in = '0;
    logic        txcominit, txcomwake, txelecidle, link_up, oob_busy, oob_silence, oob_error;
    logic [31:0] txdata_out;
    logic [3:0]  txcharisk_out;
    int total = 0, bad = 0;

    oob_host_ctrl dut (
        .clk(clk), .rst(rst), .gtx_ready(gtx_ready), .oob_start(oob_start),
        .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
        .rxelecidle_in(rxelecidle_in), .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
        .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
        .txdata_out(txdata_out), .txcharisk_out(txcharisk_out), .link_up(link_up),
        .oob_busy(oob_busy), .oob_silence(oob_silence), .oob_error(oob_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, gr, st, ci, cw, ei;
        logic [31:0] rxd;
        logic [3:0]  rxk;
        logic [42:0] exp;
    } vec_t;

    vec_t  vecs[9];
    string names[9];

    function automatic logic [42:0] o(input logic ci, cw, ei, input logic [31:0] d,
                                      input logic [3:0] k, input logic l, b, s, e);
        return {ci, cw, ei, d, k, l, b, s, e};
    endfunction

    function automatic vec_t mk(input logic r, gr, st, ci, cw, ei, input logic [31:0] rxd,
                                input logic [3:0] rxk, input logic [42:0] exp);
        return {r, gr, st, ci, cw, ei, rxd, rxk, exp};
    endfunction

    function automatic logic [42:0] outs();
        return {txcominit, txcomwake, txelecidle, txdata_out, txcharisk_out,
                link_up, oob_busy, oob_silence, oob_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic goto_d102();
        int seen = 0;
        oob_start = 1'b1; tick(); oob_start = 1'b0; tick();
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0; tick(); tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (txdata_out == D102) seen = 1;
        end
        chk("reach_d102", 64'(seen), 64'd1);
    endtask

    task automatic count_until_error(input string name);
        int first = -1;
        for (int i = 1; i <= 1100 && first < 0; i++) begin
            tick();
            if (oob_error) first = i;
        end
        chk(name, 64'(first), 64'd1000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [42:0] ro, wc;
        int first;
        ro = o(0, 0, 1, 32'h0, 4'h0, 0, 0, 0, 0);
        wc = o(0, 0, 1, 32'h0, 4'h0, 0, 1, 0, 0);
        vecs[0] = mk(1, 1, 0, 0, 0, 0, 32'h0, 4'h0, ro);                          names[0] = "reset";
        vecs[1] = mk(0, 0, 1, 0, 0, 0, 32'h0, 4'h0, ro);                          names[1] = "gtx_low";
        vecs[2] = mk(0, 1, 1, 0, 0, 0, 32'h0, 4'h0, o(1, 0, 1, 0, 0, 0, 1, 0, 0)); names[2] = "comreset";
        vecs[3] = mk(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, wc);                          names[3] = "wait_cominit";
        vecs[4] = mk(0, 1, 1, 0, 0, 0, 32'h0, 4'h0, wc);                          names[4] = "start_busy";
        vecs[5] = mk(0, 1, 0, 1, 0, 0, 32'h0, 4'h0, wc);                          names[5] = "cominit_reg";
        vecs[6] = mk(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, o(0, 1, 1, 0, 0, 0, 1, 0, 0)); names[6] = "comwake";
        vecs[7] = mk(0, 1, 0, 0, 0, 0, 32'h0, 4'h0, wc);                          names[7] = "wait_comwake";
        vecs[8] = mk(0, 1, 0, 0, 0, 0, ALIGN, 4'h1, wc);                          names[8] = "stray_align";
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; gtx_ready = vecs[i].gr; oob_start = vecs[i].st;
            rxcominitdet_in = vecs[i].ci; rxcomwakedet_in = vecs[i].cw; rxelecidle_in = vecs[i].ei;
            rxdata_in = vecs[i].rxd; rxcharisk_in = vecs[i].rxk;
            tick();
            chk(names[i], 64'(outs()), 64'(vecs[i].exp));
        end
        oob_start = 1'b0; rxdata_in = '0; rxcharisk_in = '0;

        for (int p = 0; p < 2; p++) begin
            rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
            repeat (9) tick();
        end
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        repeat (38) tick();
        chk("d102_early", {txelecidle, txdata_out}, {1'b1, 32'h0});
        tick();
        chk("d102_start", {txelecidle, txdata_out, txcharisk_out}, {1'b0, D102, 4'h0});

        rxdata_in = ALIGN; rxcharisk_in = 4'h1; tick();
        chk("align_lat", txdata_out, D102);
        rxdata_in = '0; rxcharisk_in = '0; tick();
        chk("send_align", {txdata_out, txcharisk_out, link_up}, {ALIGN, 4'h1, 1'b0});

        rxdata_in = SYNC; rxcharisk_in = 4'h1; tick();
        chk("sync_lat", link_up, 1'b0);
        rxdata_in = '0; rxcharisk_in = '0; tick();
        chk("link_up", {link_up, oob_busy, txelecidle, txdata_out, txcharisk_out}, {2'b10, 1'b0, SYNC, 4'h1});
        repeat (3) tick();
        chk("link_hold", {link_up, txdata_out}, {1'b1, SYNC});

        rxelecidle_in = 1'b1; tick();
        chk("loss_lat", {link_up, oob_error}, 2'b10);
        rxelecidle_in = 1'b0; tick();
        chk("loss_err", {link_up, oob_error, txelecidle, txdata_out, oob_silence}, {3'b011, 32'h0, 1'b0});
        tick();
        chk("loss_idle", {oob_error, oob_busy, link_up}, 3'b000);

        oob_start = 1'b1; tick(); oob_start = 1'b0; tick();
        first = -1;
        for (int i = 1; i <= 1100 && first < 0; i++) begin
            tick();
            if (oob_silence) first = i;
        end
        chk("silence_time", 64'(first), 64'd1000);
        chk("silence_state", {oob_busy, txelecidle, oob_error}, 3'b010);
        tick();
        chk("silence_width", {oob_silence, oob_busy}, 2'b00);

        goto_d102();
        count_until_error("noalign_time");
        chk("noalign_state", {txelecidle, txdata_out, txcharisk_out, oob_silence}, {1'b1, 32'h0, 4'h0, 1'b0});
        tick();
        chk("noalign_idle", {oob_error, oob_busy}, 2'b00);

        goto_d102();
        repeat (998) tick();
        rxdata_in = ALIGN; rxcharisk_in = 4'h1; tick();
        rxdata_in = '0; rxcharisk_in = '0; tick();
        chk("race_align", {txdata_out, txcharisk_out, oob_error, oob_busy}, {ALIGN, 4'h1, 2'b01});

        gtx_ready = 1'b0; oob_start = 1'b1; tick();
        chk("midreset", 64'(outs()), 64'(ro));
        gtx_ready = 1'b1; oob_start = 1'b0; tick();
        chk("post_reset_idle", 64'(outs()), 64'(ro));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
